// File: rtl/cache_mc_pkg.sv
// ============================================================================
// Module      : cache_mc_pkg
// Description : Width derivations and count-vector indexing for cache_mc_fifo
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_mc_pkg;

  localparam int MAX_FLAT = 1024;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int calc_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // Extracts channel ch's occupancy from the flattened count vector (channel 0 in LSBs).
  function automatic int unsigned count_at(input logic [MAX_FLAT-1:0] flat,
                                           input int ch, input int cnt_w);
    logic [MAX_FLAT-1:0] sh;
    sh = flat >> (ch * cnt_w);
    return 32'(sh) & ((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_mc_ram.sv
// ============================================================================
// Module      : cache_mc_ram
// Description : Simple dual-port RAM, one write and one registered read port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mc_ram #(
  parameter int DATA_WIDTH = 162,
  parameter int RAM_DEPTH  = 128,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Only the output register is reset; it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/cache_mc_fifo.sv
// ============================================================================
// Module      : cache_mc_fifo
// Description : Multi-channel FIFO sharing one dual-port RAM, per-channel status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mc_fifo
  import cache_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 162,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 2,
  parameter int AF_THRESH  = 56,
  localparam int CH_W      = calc_ch_w(NUM_CH),
  localparam int DEPTH     = calc_depth(ADDR_WIDTH),
  localparam int CNT_W     = calc_cnt_w(ADDR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  input  logic [NUM_CH-1:0]         flush,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH-1:0]         almost_full,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic                      ovf_err,
  output logic                      udf_err
);

  localparam int RAM_AW = CH_W + ADDR_WIDTH;

  logic [CH_W-1:0]       w_wr_idx, w_rd_idx;
  logic                  w_wr_ch_ok, w_rd_ch_ok;
  logic                  w_wr_flush, w_rd_flush;
  logic                  w_wr_fire, w_rd_fire;
  logic [ADDR_WIDTH-1:0] w_wr_ptr [NUM_CH];
  logic [ADDR_WIDTH-1:0] w_rd_ptr [NUM_CH];
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  generate
    if (NUM_CH == 1) begin : g_single
      logic w_unused_ch;
      assign w_unused_ch = ^{wr_ch, rd_ch};
      assign w_wr_idx    = '0;
      assign w_rd_idx    = '0;
      assign w_wr_ch_ok  = 1'b1;
      assign w_rd_ch_ok  = 1'b1;
    end else begin : g_multi
      assign w_wr_idx    = wr_ch;
      assign w_rd_idx    = rd_ch;
      assign w_wr_ch_ok  = ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
      assign w_rd_ch_ok  = ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH));
    end
  endgenerate

  // A flushed channel swallows its requests without raising an error.
  assign w_wr_flush = w_wr_ch_ok & flush[w_wr_idx];
  assign w_rd_flush = w_rd_ch_ok & flush[w_rd_idx];
  assign w_wr_fire  = clk_en & wr_en & w_wr_ch_ok & ~w_wr_flush & ~full[w_wr_idx];
  assign w_rd_fire  = clk_en & rd_en & w_rd_ch_ok & ~w_rd_flush & ~empty[w_rd_idx];

  always_comb begin
    rd_valid_d = rd_valid_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clk_en) begin
      rd_valid_d = w_rd_fire;
      ovf_d      = wr_en & ~w_wr_fire & ~w_wr_flush;
      udf_d      = rd_en & ~w_rd_fire & ~w_rd_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign ovf_err  = ovf_q;
  assign udf_err  = udf_q;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]      cnt_q, cnt_d;
      logic                  full_q, full_d, empty_q, empty_d, af_q, af_d;
      logic                  w_wr_hit, w_rd_hit;

      assign w_wr_hit = w_wr_fire & (w_wr_idx == CH_W'(i));
      assign w_rd_hit = w_rd_fire & (w_rd_idx == CH_W'(i));

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clk_en & flush[i]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          if (w_wr_hit) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          if (w_rd_hit) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          case ({w_wr_hit, w_rd_hit})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
          endcase
        end
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
        af_d    = (cnt_d >= CNT_W'(AF_THRESH));
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          full_q   <= 1'b0;
          empty_q  <= 1'b1;
          af_q     <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          full_q   <= full_d;
          empty_q  <= empty_d;
          af_q     <= af_d;
        end
      end

      assign full[i]                 = full_q;
      assign empty[i]                = empty_q;
      assign almost_full[i]          = af_q;
      assign count[i*CNT_W +: CNT_W] = cnt_q;
      assign w_wr_ptr[i]             = wr_ptr_q;
      assign w_rd_ptr[i]             = rd_ptr_q;
    end
  endgenerate

  cache_mc_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_DEPTH  (NUM_CH * DEPTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_fire),
    .waddr ({w_wr_idx, w_wr_ptr[w_wr_idx]}),
    .wdata (wr_data),
    .re    (w_rd_fire),
    .raddr ({w_rd_idx, w_rd_ptr[w_rd_idx]}),
    .rdata (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_mc_fifo.sv
// ============================================================================
// Module      : tb_cache_mc_fifo
// Description : Scoreboard bench for cache_mc_fifo with a queue-based model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mc_fifo;
  import cache_mc_pkg::*;

  localparam int DW    = 162;
  localparam int AW    = 6;
  localparam int NCH   = 2;
  localparam int AF    = 56;
  localparam int DEPTH = 64;
  localparam int CW    = 7;
  localparam int CHW   = 1;

  logic              clk, rst, clk_en;
  logic              wr_en, rd_en;
  logic [CHW-1:0]    wr_ch, rd_ch;
  logic [DW-1:0]     wr_data, rd_data;
  logic              rd_valid, ovf_err, udf_err;
  logic [NCH-1:0]    flush, full, empty, almost_full;
  logic [NCH*CW-1:0] count;

  cache_mc_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH),
    .AF_THRESH  (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one queue per channel plus the expected read-data queue.
  logic [DW-1:0] mq [NCH][$];
  logic [DW-1:0] exp_q [$];
  bit exp_rv, exp_ovf, exp_udf, new_out, chk_on;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int wc, rc;
    bit wok, rok, wfl, rfl;
    exp_rv = 0; exp_ovf = 0; exp_udf = 0; new_out = 0; chk_on = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int c = 0; c < NCH; c++) mq[c].delete();
        exp_q.delete();
        exp_rv = 0; exp_ovf = 0; exp_udf = 0; new_out = 0;
        chk_on = 1;
      end else if (clk_en) begin
        wc  = int'(wr_ch);
        rc  = int'(rd_ch);
        wfl = flush[wc];
        rfl = flush[rc];
        wok = wr_en && !wfl && (mq[wc].size() < DEPTH);
        rok = rd_en && !rfl && (mq[rc].size() > 0);
        if (rok) exp_q.push_back(mq[rc].pop_front());
        if (wok) mq[wc].push_back(wr_data);
        for (int c = 0; c < NCH; c++) if (flush[c]) mq[c].delete();
        exp_ovf = wr_en && !wok && !wfl;
        exp_udf = rd_en && !rok && !rfl;
        exp_rv  = rok;
        new_out = 1;
      end else begin
        new_out = 0;
      end
    end
  end

  // Status / pulse checker.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int c = 0; c < NCH; c++) begin
          chk("count", DW'(count_at(MAX_FLAT'(count), c, CW)), DW'(mq[c].size()));
          chk("full", DW'(full[c]), DW'(mq[c].size() == DEPTH));
          chk("empty", DW'(empty[c]), DW'(mq[c].size() == 0));
          chk("almost_full", DW'(almost_full[c]), DW'(mq[c].size() >= AF));
        end
        chk("ovf_err", DW'(ovf_err), DW'(exp_ovf));
        chk("udf_err", DW'(udf_err), DW'(exp_udf));
        chk("rd_valid", DW'(rd_valid), DW'(exp_rv));
      end
    end
  end

  // Read-data monitor: pops the scoreboard whenever a fresh rd_valid appears.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && new_out && rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rd_data_unexpected", DW'(1), DW'(0));
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic drive(input bit we, input int wc, input logic [DW-1:0] wd,
                       input bit re, input int rc, input logic [NCH-1:0] fl, input bit ce);
    wr_en   = we;
    wr_ch   = CHW'(wc);
    wr_data = wd;
    rd_en   = re;
    rd_ch   = CHW'(rc);
    flush   = fl;
    clk_en  = ce;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw, pr;
    rst = 1; clk_en = 1; wr_en = 0; rd_en = 0; wr_ch = '0; rd_ch = '0;
    wr_data = '0; flush = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("rd_data_reset", rd_data, DW'(0));

    drive(0, 0, '0, 1, 0, '0, 1);                        // read empty ch0
    for (int i = 0; i < 65; i++) drive(1, 0, DW'(i), 0, 0, '0, 1);
    for (int i = 0; i < 64; i++) drive(0, 0, '0, 1, 0, '0, 1);
    drive(0, 0, '0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, DW'(100 + i), 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 0, '0, 1);

    for (int i = 0; i < 4; i++) drive(1, 0, DW'(200 + i), 0, 0, '0, 1);
    drive(1, 1, DW'('hA), 1, 0, '0, 1);
    drive(1, 1, DW'('hB), 1, 0, '0, 1);

    for (int i = 0; i < 8; i++) drive(1, 0, DW'(300 + i), 0, 0, '0, 1);
    drive(1, 0, DW'(999), 1, 0, 2'b01, 1);               // flush ch0 with requests
    drive(0, 0, '0, 0, 0, '0, 1);

    for (int i = 0; i < 5; i++) drive(1, 0, DW'(400 + i), 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, DW'(500 + i), 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, DW'(600 + i), 1, 0, '0, 1);

    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 85 : 25;
      pr = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 500; i++) begin
        drive($urandom_range(99) < pw, int'($urandom_range(NCH - 1)), rnd_data(),
              $urandom_range(99) < pr, int'($urandom_range(NCH - 1)),
              {($urandom_range(63) == 0), ($urandom_range(63) == 0)},
              $urandom_range(15) != 0);
      end
    end

    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0, 0, '0, 1);
    chk("scoreboard_drain", DW'(exp_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
